// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
// Response source enum, full-strobe constant, word-address compare.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    NONE,
    I,
    D,
    D_FWD
  } resp_src_t;

  localparam int AW_MAX = 64;
  localparam logic [7:0] STRB_FULL = 8'hFF;

  function automatic logic word_hit(
    input logic [AW_MAX-1:0] a,
    input logic [AW_MAX-1:0] b
  );
    return a[AW_MAX-1:2] == b[AW_MAX-1:2];
  endfunction

endpackage

// File: rtl/mem_wr_buffer.sv
// One-entry posted store buffer with word-hit compare for load and fetch.
// Ports: load/drain controls, store bundle in, entry out, hit flags.
module mem_wr_buffer
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [SW-1:0] st_strb,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] i_addr,
  output logic          valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic [SW-1:0] wb_strb,
  output logic          d_hit,
  output logic          d_full,
  output logic          i_hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_strb <= '0;
    end else begin
      if (load) begin
        valid   <= 1'b1;
        wb_addr <= st_addr;
        wb_data <= st_data;
        wb_strb <= st_strb;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end

  assign d_hit = valid
    & word_hit(AW_MAX'(d_addr), AW_MAX'(wb_addr));
  assign i_hit = valid
    & word_hit(AW_MAX'(i_addr), AW_MAX'(wb_addr));
  assign d_full = d_hit
    & (wb_strb == STRB_FULL[SW-1:0]);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync SRAM port between fetch, load and store-buffer drain.
// Ports: i_* fetch, d_* load/store, m_* SRAM, wbuf_busy status.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_re,
  input  logic [AW-1:0]   d_raddr,
  output logic            d_rgnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  input  logic            d_we,
  input  logic [AW-1:0]   d_waddr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_wgnt,
  output logic            m_en,
  output logic [DW/8-1:0] m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  output logic            wbuf_busy
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [SW-1:0] wb_strb;
  logic          d_hit;
  logic          d_full;
  logic          i_hit;
  logic          drain;
  logic          fetch_port;
  logic          load_port;
  logic          force_drain;
  logic          starved;
  logic [CW-1:0] starve_cnt;
  resp_src_t     resp_src;
  logic          i_pend;
  logic [DW-1:0] fwd_data;

  mem_wr_buffer #(
    .AW(AW),
    .DW(DW)
  ) u_wbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (d_wgnt),
    .drain   (drain),
    .st_addr (d_waddr),
    .st_data (d_wdata),
    .st_strb (d_wstrb),
    .d_addr  (d_raddr),
    .i_addr  (i_addr),
    .valid   (wb_valid),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .wb_strb (wb_strb),
    .d_hit   (d_hit),
    .d_full  (d_full),
    .i_hit   (i_hit)
  );

  assign force_drain = (d_re & d_hit & ~d_full)
                     | (i_req & i_hit);
  assign starved = i_req
    & (starve_cnt == CW'(STARVE_MAX));

  // Idle drain holds off while a forwarded load
  // is being served so that cycle stays port-free.
  always_comb begin
    drain      = 1'b0;
    fetch_port = 1'b0;
    load_port  = 1'b0;
    if (force_drain) begin
      drain = 1'b1;
    end else if (starved) begin
      fetch_port = 1'b1;
    end else if (d_re && !d_hit) begin
      load_port = 1'b1;
    end else if (wb_valid && d_we) begin
      drain = 1'b1;
    end else if (i_req) begin
      fetch_port = 1'b1;
    end else if (wb_valid && !(d_re && d_full)) begin
      drain = 1'b1;
    end
  end

  assign i_gnt  = fetch_port;
  assign d_rgnt = load_port | (d_re & d_full);
  assign d_wgnt = d_we & (~wb_valid | drain);

  assign m_en    = drain | fetch_port | load_port;
  assign m_we    = drain ? wb_strb : '0;
  assign m_wdata = wb_data;
  always_comb begin
    m_addr = {d_raddr[AW-1:2], 2'b00};
    if (drain)
      m_addr = {wb_addr[AW-1:2], 2'b00};
    else if (fetch_port)
      m_addr = {i_addr[AW-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      resp_src   <= NONE;
      i_pend     <= 1'b0;
      fwd_data   <= '0;
    end else begin
      if (!i_req || i_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      i_pend <= fetch_port;
      if (d_re && d_full) begin
        resp_src <= D_FWD;
        fwd_data <= wb_data;
      end else if (load_port) begin
        resp_src <= D;
      end else begin
        resp_src <= NONE;
      end
    end
  end

  assign wbuf_busy = wb_valid;
  assign i_rvalid  = i_pend;
  assign i_rdata   = i_pend ? m_rdata : '0;
  assign d_rvalid  = (resp_src == D)
                   | (resp_src == D_FWD);
  always_comb begin
    d_rdata = '0;
    unique case (1'b1)
      resp_src == D:     d_rdata = m_rdata;
      resp_src == D_FWD: d_rdata = fwd_data;
      default:           d_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with an SRAM model.
// Drives on negedge, checks grants #1 later and rvalids #1 after posedge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_re;
  logic [31:0] d_raddr;
  logic        d_rgnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_we;
  logic [31:0] d_waddr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wgnt;
  logic        m_en;
  logic [3:0]  m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        wbuf_busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:1023];

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_re      (d_re),
    .d_raddr   (d_raddr),
    .d_rgnt    (d_rgnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_we      (d_we),
    .d_waddr   (d_waddr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_wgnt    (d_wgnt),
    .m_en      (m_en),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .wbuf_busy (wbuf_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (m_we[b])
            mem[m_addr[11:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem[m_addr[11:2]];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req   = 1'b0;
    i_addr  = '0;
    d_re    = 1'b0;
    d_raddr = '0;
    d_we    = 1'b0;
    d_waddr = '0;
    d_wdata = '0;
    d_wstrb = '0;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h104 >> 2] = 32'hCAFEF00D;
    mem[32'h300 >> 2] = 32'h11223344;
    m_rdata = '0;
    rst_n = 1'b0;
    idle_inputs();

    // reset state
    #1;
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_wbuf_busy", 32'(wbuf_busy), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_gnts", {29'd0, i_gnt, d_rgnt, d_wgnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single fetch
    @(negedge clk);
    i_req  = 1'b1;
    i_addr = 32'h100;
    #1;
    chk("f1_i_gnt", 32'(i_gnt), 32'd1);
    chk("f1_m_en", 32'(m_en), 32'd1);
    chk("f1_m_we", 32'(m_we), 32'd0);
    chk("f1_m_addr", m_addr, 32'h100);
    @(posedge clk);
    #1;
    chk("f1_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("f1_i_rdata", i_rdata, 32'hDEADBEEF);
    @(negedge clk);
    i_req = 1'b0;
    @(posedge clk);
    #1;
    chk("f1_i_rvalid_drop", 32'(i_rvalid), 32'd0);

    // fetch starvation: loads win 4 times, then fetch is forced
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      i_req   = 1'b1;
      i_addr  = 32'h104;
      d_re    = 1'b1;
      d_raddr = 32'h100;
      #1;
      chk($sformatf("st%0d_d_rgnt", k), 32'(d_rgnt),
          (k == 5) ? 32'd0 : 32'd1);
      chk($sformatf("st%0d_i_gnt", k), 32'(i_gnt),
          (k == 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
      if (k == 5) begin
        chk("st5_i_rvalid", 32'(i_rvalid), 32'd1);
        chk("st5_i_rdata", i_rdata, 32'hCAFEF00D);
      end else begin
        chk($sformatf("st%0d_d_rvalid", k), 32'(d_rvalid), 32'd1);
        chk($sformatf("st%0d_d_rdata", k), d_rdata, 32'hDEADBEEF);
      end
    end
    @(negedge clk);
    idle_inputs();

    // full-hit forwarding
    @(negedge clk);
    d_we    = 1'b1;
    d_waddr = 32'h200;
    d_wdata = 32'h12345678;
    d_wstrb = 4'hF;
    #1;
    chk("fw_d_wgnt", 32'(d_wgnt), 32'd1);
    chk("fw_st_m_en", 32'(m_en), 32'd0);
    @(negedge clk);
    idle_inputs();
    d_re    = 1'b1;
    d_raddr = 32'h200;
    #1;
    chk("fw_busy", 32'(wbuf_busy), 32'd1);
    chk("fw_d_rgnt", 32'(d_rgnt), 32'd1);
    chk("fw_m_en", 32'(m_en), 32'd0);
    @(posedge clk);
    #1;
    chk("fw_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("fw_d_rdata", d_rdata, 32'h12345678);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("fw_drain_m_en", 32'(m_en), 32'd1);
    chk("fw_drain_m_we", 32'(m_we), 32'hF);
    chk("fw_drain_m_addr", m_addr, 32'h200);
    chk("fw_drain_m_wdata", m_wdata, 32'h12345678);
    @(posedge clk);
    #1;
    chk("fw_busy_clear", 32'(wbuf_busy), 32'd0);
    chk("fw_mem", mem[32'h200 >> 2], 32'h12345678);

    // partial hit: load stalls behind a forced drain
    @(negedge clk);
    d_we    = 1'b1;
    d_waddr = 32'h300;
    d_wdata = 32'h000000AA;
    d_wstrb = 4'b0001;
    #1;
    chk("ph_d_wgnt", 32'(d_wgnt), 32'd1);
    @(negedge clk);
    idle_inputs();
    d_re    = 1'b1;
    d_raddr = 32'h300;
    #1;
    chk("ph_stall_d_rgnt", 32'(d_rgnt), 32'd0);
    chk("ph_drain_m_we", 32'(m_we), 32'b0001);
    chk("ph_drain_m_addr", m_addr, 32'h300);
    @(negedge clk);
    #1;
    chk("ph_d_rgnt", 32'(d_rgnt), 32'd1);
    chk("ph_m_we_read", 32'(m_we), 32'd0);
    @(posedge clk);
    #1;
    chk("ph_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("ph_d_rdata", d_rdata, 32'h112233AA);
    @(negedge clk);
    idle_inputs();

    // back-to-back stores
    @(negedge clk);
    d_we    = 1'b1;
    d_waddr = 32'h400;
    d_wdata = 32'hA5A5A5A5;
    d_wstrb = 4'hF;
    #1;
    chk("bb1_d_wgnt", 32'(d_wgnt), 32'd1);
    chk("bb1_m_en", 32'(m_en), 32'd0);
    @(negedge clk);
    d_waddr = 32'h404;
    d_wdata = 32'h5A5A0001;
    #1;
    chk("bb2_d_wgnt", 32'(d_wgnt), 32'd1);
    chk("bb2_m_en", 32'(m_en), 32'd1);
    chk("bb2_m_addr", m_addr, 32'h400);
    chk("bb2_m_we", 32'(m_we), 32'hF);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("bb3_m_addr", m_addr, 32'h404);
    chk("bb3_m_wdata", m_wdata, 32'h5A5A0001);
    @(negedge clk);
    #1;
    chk("bb_busy", 32'(wbuf_busy), 32'd0);
    chk("bb_mem0", mem[32'h400 >> 2], 32'hA5A5A5A5);
    chk("bb_mem1", mem[32'h404 >> 2], 32'h5A5A0001);

    // fetch hitting the buffer forces a drain first
    @(negedge clk);
    d_we    = 1'b1;
    d_waddr = 32'h600;
    d_wdata = 32'h0BADF00D;
    d_wstrb = 4'hF;
    @(negedge clk);
    idle_inputs();
    i_req  = 1'b1;
    i_addr = 32'h600;
    #1;
    chk("fh_stall_i_gnt", 32'(i_gnt), 32'd0);
    chk("fh_drain_m_we", 32'(m_we), 32'hF);
    chk("fh_drain_m_addr", m_addr, 32'h600);
    @(negedge clk);
    #1;
    chk("fh_i_gnt", 32'(i_gnt), 32'd1);
    @(posedge clk);
    #1;
    chk("fh_i_rdata", i_rdata, 32'h0BADF00D);
    @(negedge clk);
    idle_inputs();

    // reset after a load grant with a store just buffered
    @(negedge clk);
    d_re    = 1'b1;
    d_raddr = 32'h100;
    d_we    = 1'b1;
    d_waddr = 32'h500;
    d_wdata = 32'h77777777;
    d_wstrb = 4'hF;
    #1;
    chk("rs_d_rgnt", 32'(d_rgnt), 32'd1);
    chk("rs_d_wgnt", 32'(d_wgnt), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rs_busy", 32'(wbuf_busy), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rs_m_en", 32'(m_en), 32'd0);
    @(posedge clk);
    #1;
    chk("rs_d_rvalid_after", 32'(d_rvalid), 32'd0);
    chk("rs_mem_discard", mem[32'h500 >> 2], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous SRAM between the IF-stage instruction fetch and the EXE/MEM-stage data read and write ports. It contains a 1-entry posted write buffer with read forwarding, and it arbitrates fetch, load and buffer drain cycle by cycle. Fetch has starvation protection. It sits between the core top level and a unified memory macro.

Parameters:
AW, 32, address width
DW, 32, data width (strobe width DW/8)
STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to top priority

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
i_req  input  1  fetch request; held with i_addr until i_gnt
i_addr  input  AW  fetch byte address
i_gnt  output  1  fetch accepted this cycle (combinational)
i_rvalid  output  1  fetch data valid (cycle after i_gnt)
i_rdata  output  DW  fetch data
d_re  input  1  load request; held with d_raddr until d_rgnt
d_raddr  input  AW  load byte address
d_rgnt  output  1  load accepted this cycle
d_rvalid  output  1  load data valid (cycle after d_rgnt)
d_rdata  output  DW  load data
d_we  input  1  store request; held until d_wgnt
d_waddr  input  AW  store byte address
d_wdata  input  DW  store data
d_wstrb  input  DW/8  byte enables
d_wgnt  output  1  store accepted into write buffer
m_en  output  1  SRAM access enable
m_we  output  DW/8  SRAM byte write enables (0 = read)
m_addr  output  AW  SRAM word address, {addr[AW-1:2],2'b00}
m_wdata  output  DW  SRAM write data
m_rdata  input  DW  SRAM read data, valid one cycle after read enable
wbuf_busy  output  1  write buffer holds an undrained entry

Behaviour:
- Reset (async, rst_n=0):
  - Registers: wb_valid=0, starve_cnt=0, resp_src=NONE.
  - Outputs: i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, wbuf_busy=0.
  - With no requests, all grants are 0 and m_en=0.
  - Reset mid-operation drops any pending rvalid and discards the buffered write.
- Write buffer (1 entry: addr, data, strb):
  - d_wgnt = d_we & (!wb_valid | drain_grant). Drain and refill in the same cycle is legal.
  - An accepted entry is loaded at the next edge. wbuf_busy = wb_valid.
- Buffer hit: addr[AW-1:2]==wb_addr[AW-1:2] & wb_valid.
  - Full hit (hit & wb_strb all ones): a load is served from the buffer. d_rgnt=1, no SRAM use, resp_src=D_FWD, d_rdata=wb_data next cycle.
  - Partial hit (hit, strb not all ones) on a load, or any hit on a fetch: that request is not granted, and the drain is forced this cycle.
- Arbitration: one SRAM grant per cycle, first match wins:
  1. Forced drain (partial load hit or fetch hit).
  2. Fetch, if i_req & starve_cnt==STARVE_MAX.
  3. Load (d_re, no hit).
  4. Drain, if wb_valid & d_we (buffer full, store blocked).
  5. Fetch.
  6. Idle drain, if wb_valid.
- Forwarded loads do not consume the port, so a full-hit load and a fetch may both be granted in one cycle.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when i_req & !i_gnt.
  - Clears when i_gnt or !i_req.
- Response pipeline:
  - resp_src register takes {NONE, I, D, D_FWD} per grant; a forwarded load and a fetch in the same cycle are tracked separately.
  - The rvalid for each accepted read is asserted exactly one cycle after its grant.
  - rdata is taken from m_rdata for SRAM reads, or from the registered forward data for D_FWD.
  - Back-to-back grants give back-to-back rvalids, for a throughput of 1 per cycle.
- Same-cycle load and store to the same address: the load sees the pre-store contents, because forwarding checks only the current buffer contents.
- Drain cycle: m_en=1, m_we=wb_strb, m_wdata=wb_data; wb_valid clears at the edge unless refilled.
- Requesters must not change addr or data while req is high and gnt is low.

Decomposition:
- Package mem_arb_pkg: resp_src_t enum {NONE, I, D, D_FWD}; STRB_FULL constant; hit-compare function.
- Sub-module mem_wr_buffer: 1-entry store buffer holding valid/addr/data/strb, with load/drain controls and full/partial hit outputs.
- Arbitration, starvation counter and response pipeline stay in mem_port_arbiter.

Test Plan:
- Reset, then i_req with i_addr=0x100 and SRAM[0x100]=0xDEADBEEF → i_gnt in the same cycle; i_rvalid with 0xDEADBEEF next cycle; m_we=0.
- d_re and i_req held continuously for 6 cycles → load granted in cycles 1–4; fetch forced in cycle 5 (starve_cnt=4); starve_cnt then 0.
- Store 0x12345678 to 0x200 (strb=F), then load 0x200 next cycle → d_rgnt=1 with m_en=0; d_rdata=0x12345678; the buffer drains on the first idle cycle.
- Store strb=4'b0001 to 0x300, then load 0x300 → load stalled one cycle; drain written with m_we=1; load granted after the drain.
- Two back-to-back stores with the port idle → second d_wgnt coincides with the drain of the first; final SRAM holds both values.
- Assert rst_n=0 one cycle after a load grant → d_rvalid stays 0; wbuf_busy=0 after reset.
